frame_scheduler: RTL

- Sequences one snapshot cycle over the shared capture datapath: camera frame capture into the buffer RAM, colour decision latch, image upload over the PC UART, colour report to the Arduino.
- Owns the buffer RAM write enable so the image sender never reads a frame that is still being written.
- Sits between pixel_catcher/color_finder (write side), image_sender (read side) and arduinoUART; one clk domain; vsync/href inputs arrive already synchronised to clk.

---
 rtl/frame_sched_pkg.sv | 18 +
 rtl/frame_scheduler_watchdog.sv | 33 +++
 rtl/frame_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// Shared definitions for the snapshot scheduler: state encoding and frame geometry
// used by the write side (pixel_catcher) and the read side (image_sender).
package frame_sched_pkg;

   localparam int DEFAULT_ADDR_W       = 13;
   localparam int DEFAULT_FRAME_PIXELS = 4800;        // 80x60
   localparam int DEFAULT_TIMEOUT      = 12_500_000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      CAPTURE = 3'd2,
      LATCH   = 3'd3,
      SEND    = 3'd4,
      REPORT  = 3'd5
   } sched_state_t;

endpackage

// File: rtl/frame_scheduler_watchdog.sv
// Watchdog for the SEND/REPORT handshakes: cleared on state entry, counts while
// enabled, and flags expiry on the TIMEOUT-th cycle spent in the state.
module sched_watchdog
   import frame_sched_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int               CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign expire = en && (cnt == LAST);

   // NOTE: clocked state is always assigned with <=, so every register samples
   // pre-edge values and block ordering cannot change the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expire)
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/frame_scheduler.sv
// Snapshot sequencer: capture a frame into the buffer RAM, latch the colour,
// upload the image, report the colour, with write gating and a handshake watchdog.
module frame_scheduler
   import frame_sched_pkg::*;
#(
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
   parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_req,
   input  logic              continuous,
   input  logic              vsync_s,
   input  logic              regwrite_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [2:0]        color_code_in,
   input  logic              send_done,
   input  logic              report_done,
   output logic              regwrite_out,
   output logic              send_start,
   output logic              report_start,
   output logic [2:0]        color_code,
   output logic              busy,
   output logic              short_frame,
   output logic              timeout_err,
   output logic [7:0]        frame_cnt
);

   localparam int                CNT_W      = $clog2(FRAME_PIXELS + 1);
   localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_PIXELS);
   localparam logic [ADDR_W:0]   ADDR_LIM   = (ADDR_W + 1)'(FRAME_PIXELS);

   sched_state_t     state, state_nxt;
   logic             cap_req_d, vsync_d, pending, first_cycle;
   logic             cap_rise, vs_rise, wr_pass;
   logic             wd_clr, wd_en, wd_expire;
   logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;

   assign cap_rise   = cap_req & ~cap_req_d;
   assign vs_rise    = vsync_s & ~vsync_d;
   assign wr_pass    = (state == CAPTURE) && regwrite_in && ({1'b0, addr_in} < ADDR_LIM);
   assign wr_cnt_nxt = wr_cnt + CNT_W'(wr_pass);
   assign busy       = (state != IDLE);

   // Any state change clears the watchdog, so SEND and REPORT each get a full budget.
   assign wd_clr = (state_nxt != state);
   assign wd_en  = (state == SEND) || (state == REPORT);

   sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt    = state;
      regwrite_out = 1'b0;
      send_start   = 1'b0;
      report_start = 1'b0;
      unique case (state)
         IDLE:    if (cap_rise || pending || continuous) state_nxt = WAIT_VS;
         WAIT_VS: if (vs_rise) state_nxt = CAPTURE;
         CAPTURE: begin
            regwrite_out = wr_pass;
            if (vs_rise || (wr_cnt_nxt == FRAME_LAST)) state_nxt = LATCH;
         end
         LATCH:   state_nxt = SEND;
         SEND: begin
            send_start = first_cycle;
            if (send_done)      state_nxt = REPORT;
            else if (wd_expire) state_nxt = IDLE;
         end
         REPORT: begin
            report_start = first_cycle;
            if (report_done || wd_expire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cap_req_d   <= 1'b0;
         vsync_d     <= 1'b0;
         first_cycle <= 1'b0;
         pending     <= 1'b0;
         wr_cnt      <= '0;
         color_code  <= 3'd0;
         short_frame <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         state       <= state_nxt;
         cap_req_d   <= cap_req;
         vsync_d     <= vsync_s;
         first_cycle <= (state_nxt != state);

         // A request that arrives while busy is remembered once, not counted.
         if (state == IDLE && state_nxt == WAIT_VS) begin
            pending     <= 1'b0;
            short_frame <= 1'b0;
            timeout_err <= 1'b0;
         end else if (cap_rise && state != IDLE) begin
            pending <= 1'b1;
         end

         if (state == WAIT_VS)
            wr_cnt <= '0;
         else if (state == CAPTURE)
            wr_cnt <= wr_cnt_nxt;

         // A write landing together with the vsync edge still completes the frame.
         if (state == CAPTURE && vs_rise && wr_cnt_nxt != FRAME_LAST)
            short_frame <= 1'b1;

         if (state == LATCH)
            color_code <= color_code_in;

         if ((state == SEND && !send_done && wd_expire) ||
             (state == REPORT && !report_done && wd_expire))
            timeout_err <= 1'b1;

         if (state == REPORT && report_done)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule
